// File: rtl/custom_instr_dispatch.sv
// custom_instr_dispatch: single-slot X-interface sequencer (issue/commit in, unit start/operands/done bus, valid/ready result out)
module custom_instr_dispatch #(
  parameter int         N_UNITS  = 4,
  parameter int         ID_WIDTH = 4,
  parameter int         TIMEOUT  = 64,
  parameter logic [6:0] OPCODE   = 7'h0B
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [ID_WIDTH-1:0]   issue_id_i,
  input  logic [31:0]           issue_rs0_i,
  input  logic [31:0]           issue_rs1_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [ID_WIDTH-1:0]   commit_id_i,
  input  logic                  commit_kill_i,
  output logic [N_UNITS-1:0]    unit_start_o,
  output logic [31:0]           unit_rs0_o,
  output logic [31:0]           unit_rs1_o,
  input  logic [N_UNITS-1:0]    unit_done_i,
  input  logic [32*N_UNITS-1:0] unit_rd_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [ID_WIDTH-1:0]   result_id_o,
  output logic [4:0]            result_rd_o,
  output logic [31:0]           result_data_o,
  output logic                  result_err_o,
  output logic                  busy_o
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT_COMMIT, EXEC, RESULT} state_t;
  state_t             state;
  logic [N_UNITS-1:0] sel_oh;
  logic [N_UNITS-1:0] new_oh;
  logic [CW-1:0]      cnt;
  logic [31:0]        rd_sel;
  logic               decode_ok;
  logic               accept;
  logic               hit;
  logic               got_done;
  logic               unused;
  assign unused            = ^issue_instr_i[31:15];
  assign issue_ready_o     = state == IDLE;
  assign busy_o            = state != IDLE;
  assign decode_ok         = issue_instr_i[6:0] == OPCODE && int'(issue_instr_i[14:12]) < N_UNITS;
  assign accept            = issue_valid_i && issue_ready_o && decode_ok;
  assign issue_accept_o    = accept;
  assign issue_writeback_o = accept;
  assign new_oh            = N_UNITS'(1) << issue_instr_i[14:12];
  assign hit               = commit_valid_i && commit_id_i == (state == IDLE ? issue_id_i : result_id_o);
  assign got_done          = cnt != '0 && |(unit_done_i & sel_oh);
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_UNITS; k++) rd_sel |= sel_oh[k] ? unit_rd_i[32*k +: 32] : 32'd0;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state          <= IDLE;
      sel_oh         <= '0;
      cnt            <= '0;
      unit_start_o   <= '0;
      unit_rs0_o     <= '0;
      unit_rs1_o     <= '0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_rd_o    <= '0;
      result_data_o  <= '0;
      result_err_o   <= 1'b0;
    end else begin
      unit_start_o <= '0;
      case (state)
        IDLE: if (accept) begin
          sel_oh       <= new_oh;
          result_id_o  <= issue_id_i;
          result_rd_o  <= issue_instr_i[11:7];
          unit_rs0_o   <= issue_rs0_i;
          unit_rs1_o   <= issue_rs1_i;
          cnt          <= '0;
          state        <= !hit ? WAIT_COMMIT : commit_kill_i ? IDLE : EXEC;
          unit_start_o <= hit && !commit_kill_i ? new_oh : '0;
        end
        WAIT_COMMIT: if (hit) begin
          state        <= commit_kill_i ? IDLE : EXEC;
          unit_start_o <= commit_kill_i ? '0 : sel_oh;
          cnt          <= '0;
        end
        EXEC: begin
          cnt <= cnt + 1'b1;
          if (got_done || cnt == CW'(TIMEOUT - 1)) begin
            state          <= RESULT;
            result_valid_o <= 1'b1;
            result_data_o  <= got_done ? rd_sel : 32'd0;
            result_err_o   <= !got_done;
          end
        end
        RESULT: if (result_ready_i) begin
          state          <= IDLE;
          result_valid_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_custom_instr_dispatch.sv
// tb_custom_instr_dispatch: directed self-checking bench for custom_instr_dispatch
module tb_custom_instr_dispatch;
  localparam int NU = 4;
  localparam int IW = 4;
  localparam int TO = 8;
  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           issue_valid_i = 1'b0;
  logic           issue_ready_o;
  logic [31:0]    issue_instr_i = '0;
  logic [IW-1:0]  issue_id_i = '0;
  logic [31:0]    issue_rs0_i = '0;
  logic [31:0]    issue_rs1_i = '0;
  logic           issue_accept_o;
  logic           issue_writeback_o;
  logic           commit_valid_i = 1'b0;
  logic [IW-1:0]  commit_id_i = '0;
  logic           commit_kill_i = 1'b0;
  logic [NU-1:0]  unit_start_o;
  logic [31:0]    unit_rs0_o;
  logic [31:0]    unit_rs1_o;
  logic [NU-1:0]  unit_done_i = '0;
  logic [32*NU-1:0] unit_rd_i = '0;
  logic           result_valid_o;
  logic           result_ready_i = 1'b0;
  logic [IW-1:0]  result_id_o;
  logic [4:0]     result_rd_o;
  logic [31:0]    result_data_o;
  logic           result_err_o;
  logic           busy_o;
  int checks = 0;
  int errors = 0;
  custom_instr_dispatch #(.N_UNITS(NU), .ID_WIDTH(IW), .TIMEOUT(TO), .OPCODE(7'h0B)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
    .issue_id_i(issue_id_i), .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .unit_start_o(unit_start_o), .unit_rs0_o(unit_rs0_o), .unit_rs1_o(unit_rs1_o),
    .unit_done_i(unit_done_i), .unit_rd_i(unit_rd_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_rd_o(result_rd_o), .result_data_o(result_data_o), .result_err_o(result_err_o),
    .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'b0, f3, rd, op};
  endfunction
  task automatic drive_issue(input logic [31:0] instr, input logic [IW-1:0] id, input logic [31:0] a, input logic [31:0] b, input logic same_commit);
    issue_valid_i  = 1'b1;
    issue_instr_i  = instr;
    issue_id_i     = id;
    issue_rs0_i    = a;
    issue_rs1_i    = b;
    commit_valid_i = same_commit;
    commit_id_i    = id;
    commit_kill_i  = 1'b0;
    #1;
  endtask
  task automatic clr;
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    commit_id_i    = '0;
  endtask
  task automatic test_reset;
    rst_ni = 1'b0;
    #1;
    checks++; if ({issue_ready_o, busy_o, issue_accept_o, issue_writeback_o} !== 4'b1000) begin errors++; $display("FAIL reset_ctrl got %b exp 1000", {issue_ready_o, busy_o, issue_accept_o, issue_writeback_o}); end
    checks++; if ({unit_start_o, unit_rs0_o, unit_rs1_o} !== '0) begin errors++; $display("FAIL reset_unit got start=%b rs0=%h rs1=%h exp zeros", unit_start_o, unit_rs0_o, unit_rs1_o); end
    checks++; if ({result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o} !== '0) begin errors++; $display("FAIL reset_result got v=%b id=%h rd=%h d=%h e=%b exp zeros", result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask
  task automatic test_cntb;
    drive_issue(mk(7'h0B, 3'd0, 5'd5), 4'd2, 32'hF000_0000, 32'd31, 1'b1);
    checks++; if ({issue_accept_o, issue_writeback_o} !== 2'b11) begin errors++; $display("FAIL cntb_accept got %b exp 11", {issue_accept_o, issue_writeback_o}); end
    @(negedge clk_i); clr();
    checks++; if (unit_start_o !== 4'b0001) begin errors++; $display("FAIL cntb_start got %b exp 0001", unit_start_o); end
    checks++; if ({unit_rs0_o, unit_rs1_o} !== {32'hF000_0000, 32'd31}) begin errors++; $display("FAIL cntb_ops got %h %h exp f0000000 0000001f", unit_rs0_o, unit_rs1_o); end
    @(negedge clk_i);
    checks++; if ({unit_start_o, busy_o} !== 5'b00001) begin errors++; $display("FAIL cntb_start_once got start=%b busy=%b exp 0000 1", unit_start_o, busy_o); end
    @(negedge clk_i);
    unit_done_i = 4'b0001;
    unit_rd_i[31:0] = 32'd4;
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL cntb_early_valid got %b exp 0", result_valid_o); end
    @(negedge clk_i);
    unit_done_i = '0;
    checks++; if ({result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o} !== {1'b1, 4'd2, 5'd5, 32'd4, 1'b0}) begin errors++; $display("FAIL cntb_result got v=%b id=%0d rd=%0d d=%h e=%b exp 1 2 5 4 0", result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o); end
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL cntb_ready_busy got %b exp 0", issue_ready_o); end
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    checks++; if ({result_valid_o, issue_ready_o, busy_o} !== 3'b010) begin errors++; $display("FAIL cntb_done got %b exp 010", {result_valid_o, issue_ready_o, busy_o}); end
  endtask
  task automatic test_reject;
    drive_issue(mk(7'h33, 3'd0, 5'd5), 4'd1, 32'd1, 32'd2, 1'b1);
    checks++; if ({issue_ready_o, issue_accept_o, issue_writeback_o} !== 3'b100) begin errors++; $display("FAIL reject_opcode got %b exp 100", {issue_ready_o, issue_accept_o, issue_writeback_o}); end
    @(negedge clk_i);
    checks++; if ({busy_o, unit_start_o} !== 5'b0) begin errors++; $display("FAIL reject_opcode_state got busy=%b start=%b exp 0 0000", busy_o, unit_start_o); end
    drive_issue(mk(7'h0B, 3'd5, 5'd5), 4'd1, 32'd1, 32'd2, 1'b1);
    checks++; if ({issue_accept_o, issue_writeback_o} !== 2'b00) begin errors++; $display("FAIL reject_funct3 got %b exp 00", {issue_accept_o, issue_writeback_o}); end
    @(negedge clk_i); clr();
    checks++; if ({busy_o, unit_start_o, result_valid_o} !== 6'b0) begin errors++; $display("FAIL reject_funct3_state got busy=%b start=%b v=%b exp 0", busy_o, unit_start_o, result_valid_o); end
  endtask
  task automatic test_deferred;
    drive_issue(mk(7'h0B, 3'd2, 5'd7), 4'd2, 32'd1, 32'd2, 1'b0);
    checks++; if (issue_accept_o !== 1'b1) begin errors++; $display("FAIL defer_accept got %b exp 1", issue_accept_o); end
    @(negedge clk_i); clr();
    commit_valid_i = 1'b1;
    commit_id_i = 4'd3;
    checks++; if ({busy_o, issue_ready_o, unit_start_o} !== 6'b100000) begin errors++; $display("FAIL defer_wait got busy=%b rdy=%b start=%b exp 1 0 0000", busy_o, issue_ready_o, unit_start_o); end
    @(negedge clk_i);
    commit_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (unit_start_o !== 4'b0) begin errors++; $display("FAIL defer_nomatch_start%0d got %b exp 0000", i, unit_start_o); end
      @(negedge clk_i);
    end
    commit_valid_i = 1'b1;
    commit_id_i = 4'd2;
    checks++; if (unit_start_o !== 4'b0) begin errors++; $display("FAIL defer_prestart got %b exp 0000", unit_start_o); end
    @(negedge clk_i); clr();
    checks++; if (unit_start_o !== 4'b0100) begin errors++; $display("FAIL defer_start got %b exp 0100", unit_start_o); end
    @(negedge clk_i);
    unit_done_i = 4'b0100;
    unit_rd_i[95:64] = 32'hDEAD_BEEF;
    @(negedge clk_i);
    unit_done_i = '0;
    checks++; if ({result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o} !== {1'b1, 4'd2, 5'd7, 32'hDEAD_BEEF, 1'b0}) begin errors++; $display("FAIL defer_result got v=%b id=%0d rd=%0d d=%h e=%b exp 1 2 7 deadbeef 0", result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o); end
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    drive_issue(mk(7'h0B, 3'd1, 5'd3), 4'd2, 32'd5, 32'd6, 1'b0);
    checks++; if (issue_accept_o !== 1'b1) begin errors++; $display("FAIL kill_accept got %b exp 1", issue_accept_o); end
    @(negedge clk_i); clr();
    commit_valid_i = 1'b1;
    commit_id_i = 4'd2;
    commit_kill_i = 1'b1;
    @(negedge clk_i); clr();
    checks++; if ({busy_o, issue_ready_o, unit_start_o, result_valid_o} !== 7'b0100000) begin errors++; $display("FAIL kill_idle got busy=%b rdy=%b start=%b v=%b exp 0 1 0000 0", busy_o, issue_ready_o, unit_start_o, result_valid_o); end
    @(negedge clk_i);
    checks++; if ({unit_start_o, result_valid_o} !== 5'b0) begin errors++; $display("FAIL kill_quiet got start=%b v=%b exp 0000 0", unit_start_o, result_valid_o); end
  endtask
  task automatic test_timeout;
    unit_rd_i = {4{32'h5555_AAAA}};
    drive_issue(mk(7'h0B, 3'd1, 5'd9), 4'd7, 32'd0, 32'd0, 1'b1);
    @(negedge clk_i); clr();
    checks++; if (unit_start_o !== 4'b0010) begin errors++; $display("FAIL to_start got %b exp 0010", unit_start_o); end
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk_i);
      checks++; if ({result_valid_o, unit_start_o} !== 5'b0) begin errors++; $display("FAIL to_wait%0d got v=%b start=%b exp 0 0000", i, result_valid_o, unit_start_o); end
    end
    @(negedge clk_i);
    checks++; if ({result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o} !== {1'b1, 4'd7, 5'd9, 32'd0, 1'b1}) begin errors++; $display("FAIL to_result got v=%b id=%0d rd=%0d d=%h e=%b exp 1 7 9 0 1", result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o); end
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    drive_issue(mk(7'h0B, 3'd1, 5'd9), 4'd6, 32'd0, 32'd0, 1'b1);
    @(negedge clk_i); clr();
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk_i);
      if (i == 8) begin
        unit_done_i = 4'b0010;
        unit_rd_i[63:32] = 32'h1234;
      end
      checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL to_term_wait%0d got %b exp 0", i, result_valid_o); end
    end
    @(negedge clk_i);
    unit_done_i = '0;
    checks++; if ({result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o} !== {1'b1, 4'd6, 5'd9, 32'h1234, 1'b0}) begin errors++; $display("FAIL to_term_result got v=%b id=%0d rd=%0d d=%h e=%b exp 1 6 9 1234 0", result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o); end
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
  endtask
  task automatic test_backpressure;
    drive_issue(mk(7'h0B, 3'd3, 5'd12), 4'd9, 32'd1, 32'd1, 1'b1);
    checks++; if (issue_accept_o !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", issue_accept_o); end
    @(negedge clk_i); clr();
    checks++; if (unit_start_o !== 4'b1000) begin errors++; $display("FAIL bp_start got %b exp 1000", unit_start_o); end
    unit_done_i = 4'b0111;
    unit_rd_i = {32'hA5A5_0003, 32'd2, 32'd1, 32'd0};
    @(negedge clk_i);
    @(negedge clk_i);
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL bp_other_done got %b exp 0", result_valid_o); end
    unit_done_i = 4'b1000;
    @(negedge clk_i);
    unit_done_i = '0;
    for (int i = 0; i < 6; i++) begin
      checks++; if ({result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o} !== {1'b1, 4'd9, 5'd12, 32'hA5A5_0003, 1'b0}) begin errors++; $display("FAIL bp_hold%0d got v=%b id=%0d rd=%0d d=%h e=%b exp 1 9 12 a5a50003 0", i, result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o); end
      checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b exp 0", i, issue_ready_o); end
      if (i == 2) begin
        drive_issue(mk(7'h0B, 3'd0, 5'd1), 4'd1, 32'd0, 32'd0, 1'b0);
        checks++; if (issue_accept_o !== 1'b0) begin errors++; $display("FAIL bp_no_issue got %b exp 0", issue_accept_o); end
        clr();
      end
      if (i == 5) result_ready_i = 1'b1;
      @(negedge clk_i);
    end
    result_ready_i = 1'b0;
    checks++; if ({result_valid_o, issue_ready_o, busy_o} !== 3'b010) begin errors++; $display("FAIL bp_release got %b exp 010", {result_valid_o, issue_ready_o, busy_o}); end
  endtask
  task automatic test_reset_exec;
    drive_issue(mk(7'h0B, 3'd0, 5'd4), 4'd5, 32'h11, 32'h22, 1'b1);
    @(negedge clk_i); clr();
    checks++; if (unit_start_o !== 4'b0001) begin errors++; $display("FAIL rx_start got %b exp 0001", unit_start_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if ({unit_start_o, busy_o, issue_ready_o} !== 6'b000001) begin errors++; $display("FAIL rx_async got start=%b busy=%b rdy=%b exp 0000 0 1", unit_start_o, busy_o, issue_ready_o); end
    checks++; if ({unit_rs0_o, unit_rs1_o, result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o} !== '0) begin errors++; $display("FAIL rx_regs got rs0=%h rs1=%h v=%b id=%h rd=%h d=%h e=%b exp zeros", unit_rs0_o, unit_rs1_o, result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if ({unit_start_o, result_valid_o, busy_o} !== 6'b0) begin errors++; $display("FAIL rx_after got start=%b v=%b busy=%b exp 0", unit_start_o, result_valid_o, busy_o); end
    drive_issue(mk(7'h0B, 3'd2, 5'd6), 4'd4, 32'd3, 32'd4, 1'b1);
    checks++; if (issue_accept_o !== 1'b1) begin errors++; $display("FAIL rx_fresh_accept got %b exp 1", issue_accept_o); end
    @(negedge clk_i); clr();
    checks++; if ({unit_start_o, unit_rs0_o, unit_rs1_o} !== {4'b0100, 32'd3, 32'd4}) begin errors++; $display("FAIL rx_fresh_start got start=%b rs0=%h rs1=%h exp 0100 3 4", unit_start_o, unit_rs0_o, unit_rs1_o); end
    @(negedge clk_i);
    unit_done_i = 4'b0100;
    unit_rd_i[95:64] = 32'h77;
    @(negedge clk_i);
    unit_done_i = '0;
    checks++; if ({result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o} !== {1'b1, 4'd4, 5'd6, 32'h77, 1'b0}) begin errors++; $display("FAIL rx_fresh_result got v=%b id=%0d rd=%0d d=%h e=%b exp 1 4 6 77 0", result_valid_o, result_id_o, result_rd_o, result_data_o, result_err_o); end
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rx_fresh_idle got %b exp 0", busy_o); end
  endtask
  initial begin
    test_reset();
    test_cntb();
    test_reject();
    test_deferred();
    test_timeout();
    test_backpressure();
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
